// File: rtl/countdown_minsec_if.sv
// countdown_minsec_if: control/load/display bundle of the MM:SS countdown timer.
//   clear, load, start       : one-cycle command pulses from the operator side
//   ld_min2..ld_sec1 [3:0]   : BCD preset digits captured on load
//   min2..sec1 [6:0]         : active-low seven-segment digits, bit6..0 = g..a
//   running, done            : status flags (RUN state / DONE state)
// master drives the commands and presets; slave is the timer itself.
interface countdown_minsec_if;
    logic       clear;
    logic       load;
    logic       start;
    logic [3:0] ld_min2;
    logic [3:0] ld_min1;
    logic [3:0] ld_sec2;
    logic [3:0] ld_sec1;
    logic [6:0] min2;
    logic [6:0] min1;
    logic [6:0] sec2;
    logic [6:0] sec1;
    logic       running;
    logic       done;

    modport master (
        output clear, load, start, ld_min2, ld_min1, ld_sec2, ld_sec1,
        input  min2, min1, sec2, sec1, running, done
    );

    modport slave (
        input  clear, load, start, ld_min2, ld_min1, ld_sec2, ld_sec1,
        output min2, min1, sec2, sec1, running, done
    );
endinterface

// File: rtl/countdown_minsec.sv
// countdown_minsec: programmable MM:SS countdown timer with seven-segment outputs.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : countdown_minsec_if.slave (commands, BCD presets, segments, status)
//   TICK_DIV : clk cycles per one-second tick (>= 2)
module countdown_minsec #(
    parameter int TICK_DIV = 50000000
) (
    input logic               clk,
    input logic               rst_n,
    countdown_minsec_if.slave bus
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state_q, state_d;
    logic [15:0]   time_q, time_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [6:0]    min2_q, min1_q, sec2_q, sec1_q;
    logic          running_q, running_d;
    logic          done_q, done_d;

    logic          tick;
    logic          dec_zero;
    logic [15:0]   dec_time;
    logic [15:0]   ld_time;
    logic [3:0]    m2, m1, s2, s1;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0011000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] mx);
        return (d > mx) ? mx : d;
    endfunction

    assign {m2, m1, s2, s1} = time_q;

    // Borrow ripples only while every lower digit is already zero.
    assign dec_time = {
        (s1 != 4'd0 || s2 != 4'd0 || m1 != 4'd0) ? m2 : m2 - 4'd1,
        (s1 != 4'd0 || s2 != 4'd0) ? m1 : ((m1 == 4'd0) ? 4'd9 : m1 - 4'd1),
        (s1 != 4'd0) ? s2 : ((s2 == 4'd0) ? 4'd5 : s2 - 4'd1),
        (s1 == 4'd0) ? 4'd9 : s1 - 4'd1
    };
    assign dec_zero = (dec_time == 16'd0);

    assign ld_time = {
        clamp(bus.ld_min2, 4'd9),
        clamp(bus.ld_min1, 4'd9),
        clamp(bus.ld_sec2, 4'd5),
        clamp(bus.ld_sec1, 4'd9)
    };

    assign tick = (state_q == RUN) && (pre_q == PRE_TOP);

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        pre_d   = pre_q;
        if (bus.clear) begin
            state_d = IDLE;
            time_d  = '0;
            pre_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        time_d = ld_time;
                        pre_d  = '0;
                    end else if (bus.start && time_q != 16'd0) begin
                        state_d = RUN;
                        pre_d   = '0;
                    end
                end
                RUN: begin
                    // load is ignored here, and a coincident start is ignored too.
                    pre_d = tick ? '0 : pre_q + PW'(1);
                    if (tick) time_d = dec_time;
                    if (tick && dec_zero) state_d = DONE;
                    else if (bus.start && !bus.load) state_d = PAUSE;
                end
                PAUSE: begin
                    if (bus.load) begin
                        state_d = IDLE;
                        time_d  = ld_time;
                        pre_d   = '0;
                    end else if (bus.start) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    if (bus.load) begin
                        state_d = IDLE;
                        time_d  = ld_time;
                        pre_d   = '0;
                    end
                end
            endcase
        end
        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            time_q    <= '0;
            pre_q     <= '0;
            min2_q    <= 7'b1000000;
            min1_q    <= 7'b1000000;
            sec2_q    <= 7'b1000000;
            sec1_q    <= 7'b1000000;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            pre_q     <= pre_d;
            min2_q    <= seg7(m2);
            min1_q    <= seg7(m1);
            sec2_q    <= seg7(s2);
            sec1_q    <= seg7(s1);
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign bus.min2    = min2_q;
    assign bus.min1    = min1_q;
    assign bus.sec2    = sec2_q;
    assign bus.sec1    = sec1_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_countdown_minsec.sv
// tb_countdown_minsec: vector table plus directed corner sequences for countdown_minsec (TICK_DIV=4).
module tb_countdown_minsec;
    localparam int TD = 4;
    localparam logic [6:0] SEG [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
    };

    typedef struct {
        bit          c;
        bit          l;
        bit          s;
        logic [15:0] ld;
        logic [15:0] ed;
        bit          r;
        bit          dn;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t tbl [19];

    always #5 clk = ~clk;

    countdown_minsec_if bus ();
    countdown_minsec #(.TICK_DIV(TD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    function automatic logic [29:0] ex(input logic [15:0] d, input bit r, input bit dn);
        return {SEG[d[15:12]], SEG[d[11:8]], SEG[d[7:4]], SEG[d[3:0]], r, dn};
    endfunction

    task automatic chk(input string nm, input logic [29:0] want);
        logic [29:0] got;
        got = {bus.min2, bus.min1, bus.sec2, bus.sec1, bus.running, bus.done};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply(input bit c, input bit l, input bit s, input logic [15:0] d);
        bus.clear = c;
        bus.load  = l;
        bus.start = s;
        {bus.ld_min2, bus.ld_min1, bus.ld_sec2, bus.ld_sec1} = d;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        bus.load  = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{0, 0, 1, 16'h0000, 16'h0000, 0, 0};
        tbl[1]  = '{0, 0, 0, 16'h0000, 16'h0000, 0, 0};
        tbl[2]  = '{0, 1, 0, 16'h1234, 16'h0000, 0, 0};
        tbl[3]  = '{0, 0, 0, 16'h0000, 16'h1234, 0, 0};
        tbl[4]  = '{0, 1, 1, 16'h5678, 16'h1234, 0, 0};
        tbl[5]  = '{0, 0, 0, 16'h0000, 16'h5658, 0, 0};
        tbl[6]  = '{0, 1, 0, 16'hFFFF, 16'h5658, 0, 0};
        tbl[7]  = '{0, 0, 0, 16'h0000, 16'h9959, 0, 0};
        tbl[8]  = '{0, 1, 0, 16'h0100, 16'h9959, 0, 0};
        tbl[9]  = '{0, 0, 0, 16'h0000, 16'h0100, 0, 0};
        tbl[10] = '{0, 0, 1, 16'h0000, 16'h0100, 1, 0};
        tbl[11] = '{0, 0, 0, 16'h0000, 16'h0100, 1, 0};
        tbl[12] = '{0, 0, 0, 16'h0000, 16'h0100, 1, 0};
        tbl[13] = '{0, 0, 0, 16'h0000, 16'h0100, 1, 0};
        tbl[14] = '{0, 0, 0, 16'h0000, 16'h0100, 1, 0};
        tbl[15] = '{0, 0, 0, 16'h0000, 16'h0059, 1, 0};
        tbl[16] = '{0, 1, 0, 16'h0001, 16'h0059, 1, 0};
        tbl[17] = '{1, 0, 0, 16'h0000, 16'h0059, 0, 0};
        tbl[18] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 0};

        bus.clear = 1'b0;
        bus.load  = 1'b0;
        bus.start = 1'b0;
        {bus.ld_min2, bus.ld_min1, bus.ld_sec2, bus.ld_sec1} = 16'h0000;
        #12;
        chk("reset", ex(16'h0000, 0, 0));
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            apply(tbl[i].c, tbl[i].l, tbl[i].s, tbl[i].ld);
            chk($sformatf("vec%0d", i), ex(tbl[i].ed, tbl[i].r, tbl[i].dn));
        end

        apply(0, 1, 0, 16'h0002);
        apply(0, 0, 1, 16'h0000);
        idle(6);
        chk("zero_mid", ex(16'h0001, 1, 0));
        idle(1);
        chk("zero_pre", ex(16'h0001, 1, 0));
        idle(1);
        chk("zero_done", ex(16'h0001, 0, 1));
        idle(1);
        chk("zero_disp", ex(16'h0000, 0, 1));
        apply(0, 0, 1, 16'h0000);
        idle(2);
        apply(0, 0, 1, 16'h0000);
        chk("done_hold", ex(16'h0000, 0, 1));
        apply(0, 1, 0, 16'h0005);
        chk("done_load", ex(16'h0000, 0, 0));
        idle(1);
        chk("done_load_disp", ex(16'h0005, 0, 0));

        apply(0, 1, 0, 16'h0010);
        apply(0, 0, 1, 16'h0000);
        idle(2);
        apply(0, 0, 1, 16'h0000);
        chk("pause", ex(16'h0010, 0, 0));
        idle(20);
        chk("pause_hold", ex(16'h0010, 0, 0));
        apply(0, 0, 1, 16'h0000);
        chk("resume", ex(16'h0010, 1, 0));
        idle(1);
        chk("resume_1", ex(16'h0010, 1, 0));
        idle(1);
        chk("resume_2", ex(16'h0009, 1, 0));

        apply(1, 0, 0, 16'h0000);
        apply(0, 1, 0, 16'h0005);
        apply(0, 0, 1, 16'h0000);
        idle(3);
        apply(0, 0, 1, 16'h0000);
        chk("tick_start", ex(16'h0005, 0, 0));
        idle(1);
        chk("tick_start_disp", ex(16'h0004, 0, 0));

        apply(0, 1, 0, 16'h1000);
        apply(0, 0, 1, 16'h0000);
        idle(5);
        chk("borrow", ex(16'h0959, 1, 0));

        apply(1, 0, 0, 16'h0000);
        apply(0, 1, 0, 16'hFFFF);
        apply(0, 0, 1, 16'h0000);
        idle(1);
        apply(0, 1, 0, 16'h0001);
        idle(3);
        chk("clamp_run1", ex(16'h9958, 1, 0));
        idle(4);
        chk("clamp_run2", ex(16'h9957, 1, 0));

        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", ex(16'h0000, 0, 0));
        #2;
        rst_n = 1'b1;
        idle(2);
        chk("post_rst", ex(16'h0000, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/countdown_minsec.md
Name: countdown_minsec

Overview:
- Programmable MM:SS countdown timer, the down-counting counterpart of the team's up-counting minute/second counter.
- Operator presets the time as BCD digits, then starts, pauses and resumes the count.
- Drives the same four active-low seven-segment digit outputs.
- Asserts done at 00:00, for board-level alarm/LED logic.

Parameters:
- TICK_DIV, 50000000, clk cycles per 1-second tick; minimum 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- clear  input  1  synchronous clear pulse; highest priority after reset
- load  input  1  one-cycle pulse; captures the ld_* digits
- ld_min2  input  4  minute tens, BCD
- ld_min1  input  4  minute units, BCD
- ld_sec2  input  4  second tens, BCD
- ld_sec1  input  4  second units, BCD
- start  input  1  one-cycle pulse; start / pause / resume toggle
- min2  output  7  minute-tens segments, active-low, bit6..0 = g..a
- min1  output  7  minute-units segments
- sec2  output  7  second-tens segments
- sec1  output  7  second-units segments
- running  output  1  high while in RUN
- done  output  1  high while in DONE

Behaviour:
- Reset (rst_n low, async):
  - all digits 0; all segment outputs 7'b1000000
  - running=0, done=0, prescaler=0, state IDLE
- Segment encoding (digit -> pattern):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000
  - Outputs are registered: they follow a digit change by exactly 1 cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; tick is the cycle it equals TICK_DIV-1, then it wraps to 0.
  - Holds its value in PAUSE; cleared on entering RUN from IDLE, on load, and on clear.
- States: IDLE, RUN, PAUSE, DONE.
  - IDLE: load captures digits. start with nonzero time -> RUN. start with 00:00 -> ignored.
  - RUN: each tick decrements the time once. start -> PAUSE. load -> ignored.
  - Transition RUN -> DONE: on the tick where the decrement produces 00:00, in the same cycle.
  - PAUSE: start -> RUN, prescaler resumes from its held value. load captures digits -> IDLE.
  - DONE: digits hold 00:00, done=1, start ignored. load -> IDLE with done=0.
  - clear: any state -> IDLE, digits 00:00, done=0, running=0.
- Decrement and borrow chain:
  - sec1 9..0, borrowing from sec2.
  - sec2 5..0, borrowing from min1; sec1 reloads to 9.
  - min1 9..0, borrowing from min2; sec2:sec1 reloads to 59.
  - min2 9..0; min1 reloads to 9.
  - Example: 10:00 -> 09:59.
- Load clamping:
  - Any digit >9 is clamped to 9.
  - ld_sec2 >5 is clamped to 5.
  - Maximum loadable time is 99:59.
- Simultaneous events:
  - clear beats load and start.
  - load beats start in the same cycle: start is ignored, and load is applied only where load is legal.
- running = (state==RUN), registered together with the state.
- A tick and a start in the same RUN cycle: the decrement happens, then the state goes to PAUSE.
- rst_n assertion mid-count forces reset values immediately, regardless of clk.

Test Plan (TICK_DIV=4):
- Reset: assert rst_n low -> all segment outputs 1000000, running=0, done=0; no change while start is pulsed with 00:00.
- Basic tick: load 01:00, start -> running=1; after 4 cycles digits read 00:59, so the next cycle shows sec2=0010010, sec1=0011000, min1=1000000, min2=1000000.
- Reaching zero: load 00:02, start -> done=1 after 8 cycles, running=0, display 00:00; further cycles and start pulses leave it unchanged; load 00:05 -> IDLE, done=0.
- Pause/resume: load 00:10, start, wait 2 cycles, start (pause), wait 20 cycles -> display 00:10 unchanged; start again -> 00:09 appears 2 cycles later (prescaler retained).
- Clamping and ignored load: load digits F,F,F,F -> 99:59; start, then load 00:01 while in RUN -> ignored, count continues 99:58, ...
- Priority and reset: pulse load+start together in IDLE -> loaded, state stays IDLE. clear during RUN -> 00:00, IDLE. rst_n low mid-run between clk edges -> outputs reset asynchronously.
